fetch_redirect_ctrl: RTL
========================

# fetch_redirect_ctrl

Front-end PC owner and pipeline-flush sequencer; consumer of the branch predictor's outputs.
- Holds the fetch PC and runs the instruction-memory read handshake.
- Advances the PC with the predictor's `pred_addr` and redirects to `recv_addr` on `br_hazard`.
- Drives the IF/ID and ID/EX load and reset strobes that the predictor's stage registers and the datapath share.
- Counts acted-on mispredictions.

## Interface
- `RESET_PC`, default 32'h0000_0060: fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pred_addr` in 32: predicted next PC for the current `pc`.
- `br_hazard` in 1: EX-stage misprediction, valid combinationally.
- `recv_addr` in 32: correct target when `br_hazard`.
- `backend_stall` in 1: ID/EX and younger stages frozen this cycle.
- `imem_resp` in 1: instruction read data valid; level, held while `imem_read` is high and `imem_addr` is unchanged.
- `pc` out 32: current fetch PC, also fed to the predictor.
- `imem_read` out 1: read request.
- `imem_addr` out 32: read address.
- `load_ifid` out 1: capture fetched instruction into IF/ID.
- `load_idex` out 1: advance ID/EX.
- `ifid_rst` out 1: synchronous clear of IF/ID.
- `idex_rst` out 1: synchronous clear of ID/EX (flush or bubble).
- `ifid_valid` out 1: IF/ID holds a live instruction.
- `mispredict_count` out 32: redirects taken; saturates at 32'hFFFF_FFFF.

## Operation
- States: BOOT, FETCH, DRAIN.
- Derived terms:
  - `advance = ~backend_stall`
  - `flush = br_hazard & advance`
  - `accept = imem_read & imem_resp & (advance | ~ifid_valid)`
- A hazard that arrives while `backend_stall` is high is acted on only in the first cycle the stall drops.
- BOOT: entered on reset.
  - `imem_read = 0`; `ifid_rst = idex_rst = 1`.
  - Next state FETCH unconditionally.
- FETCH:
  - `imem_read = 1`, `imem_addr = pc`.
  - `accept & ~flush`: `load_ifid = 1`, `pc <= pred_addr`.
  - `flush & (accept | ~imem_read)`: response discarded, `pc <= recv_addr`, stay in FETCH.
  - `flush & imem_read & ~imem_resp`: latch `recv_addr` into `redirect_q`, go to DRAIN. `pc` and `imem_addr` stay unchanged, because the memory address must stay stable until the response.
- DRAIN:
  - `imem_read = 1`, `imem_addr = pc`.
  - On `imem_resp`: data discarded, `pc <= redirect_q`, go to FETCH.
  - A second `flush` in DRAIN overwrites `redirect_q`. This is legal because the newest redirect wins.
- Flush outputs:
  - `ifid_rst = flush` (or BOOT).
  - `idex_rst = flush | (advance & ~ifid_valid)` (or BOOT). The second term inserts a bubble.
  - `load_idex = advance`.
- `ifid_valid` next value, in priority order:
  - `flush`: 0.
  - `load_ifid`: 1.
  - `advance`: 0.
  - otherwise hold.
- `mispredict_count` increments once per `flush` cycle and saturates.

## Timing
- Reset values:
  - `pc = RESET_PC`, state = BOOT, `redirect_q = 0`, `ifid_valid = 0`, `mispredict_count = 0`.
  - `imem_read = 0`, `load_ifid = 0`, `load_idex = 1`, `ifid_rst = idex_rst = 1`.
- Fetch latency: first `imem_read` is in the cycle after BOOT.
  - A hit with `imem_resp` in the same cycle gives `load_ifid` that cycle.
  - The new `pc` is visible the next cycle.
- Redirect with no outstanding miss: `recv_addr` is on `imem_addr` one cycle after `flush`.
- Redirect with an outstanding miss: `recv_addr` is on `imem_addr` one cycle after the stale `imem_resp`.
- Simultaneous `accept` and `flush`: the flush wins; `load_ifid = 0` and no DRAIN.
- Stall with IF/ID full: `imem_read` stays high, the response is not accepted, and memory holds the data.

## Structure
- Add to `rv32i_types`: `typedef enum logic [1:0] {FR_BOOT, FR_FETCH, FR_DRAIN} fetch_state_t;`.
- Single module, no sub-modules. The counter is inline with saturation logic.

## Test plan
- Reset release:
  - Cycle 0 after `rst` rises: BOOT, `ifid_rst = idex_rst = 1`, `imem_read = 0`.
  - Cycle 1: `imem_read = 1`, `imem_addr = 0x60`.
- Sequential fetch, `pred_addr = pc + 4`, response 2 cycles after request:
  - `load_ifid` pulses once.
  - `pc` goes 0x60 -> 0x64.
  - `ifid_valid = 1` the next cycle.
- Miss outstanding at 0x64, `br_hazard` with `recv_addr = 0x200`, `imem_resp` 3 cycles later:
  - DRAIN holds `imem_addr = 0x64`; the stale response is discarded (`load_ifid = 0`).
  - Next cycle `imem_addr = 0x200`; `mispredict_count = 1`.
- `imem_resp` and `br_hazard` (`recv_addr = 0x300`) in the same cycle:
  - No `load_ifid`; `ifid_rst = idex_rst = 1`.
  - `pc = 0x300` next cycle, with no DRAIN visit.
- `backend_stall` for 4 cycles with IF/ID full and a hit pending:
  - `imem_read` stays high, `load_ifid = 0`, `pc` is stable.
  - Stall drop: accepted the same cycle.
- `br_hazard` raised during `backend_stall`:
  - No flush or count during the stall.
  - Exactly one flush and count increment on the first unstalled cycle.

Source files
------------

// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and helpers for the fetch redirect controller.
package fetch_redirect_ctrl_pkg;

  typedef enum logic [1:0] {FR_BOOT, FR_FETCH, FR_DRAIN} fetch_state_t;

  localparam logic [31:0] MISPREDICT_MAX = 32'hFFFF_FFFF;

  // Saturating increment used by the mispredict counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    if (value == MISPREDICT_MAX) begin
      return value;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl.sv
// Front-end PC owner: runs the instruction fetch handshake, follows the
// predictor, redirects on EX-stage mispredictions and sequences the
// IF/ID and ID/EX load/clear strobes.
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pred_addr,
  input  logic        br_hazard,
  input  logic [31:0] recv_addr,
  input  logic        backend_stall,
  input  logic        imem_resp,
  output logic [31:0] pc,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  output logic        load_ifid,
  output logic        load_idex,
  output logic        ifid_rst,
  output logic        idex_rst,
  output logic        ifid_valid,
  output logic [31:0] mispredict_count
);

  import fetch_redirect_ctrl_pkg::*;

  fetch_state_t state_r;
  fetch_state_t state_next_s;
  logic [31:0]  pc_r;
  logic [31:0]  pc_next_s;
  logic [31:0]  redirect_r;
  logic [31:0]  redirect_next_s;
  logic         ifid_valid_r;
  logic         ifid_valid_next_s;
  logic [31:0]  count_r;

  logic         advance_s;
  logic         flush_s;
  logic         read_active_s;
  logic         accept_s;

  // A hazard held during a stall only becomes a flush once the stall lifts.
  assign advance_s     = ~backend_stall;
  assign flush_s       = br_hazard & advance_s;
  assign read_active_s = (state_r != FR_BOOT);
  assign accept_s      = read_active_s & imem_resp & (advance_s | ~ifid_valid_r);

  assign pc               = pc_r;
  assign ifid_valid       = ifid_valid_r;
  assign mispredict_count = count_r;
  assign load_idex        = advance_s;
  assign imem_read        = read_active_s;
  // The address follows pc; pc is frozen while a stale miss drains, so the
  // memory sees a stable address until its response arrives.
  assign imem_addr        = pc_r;

  // Next-state, next-PC and strobe decode.
  always_comb begin
    state_next_s    = state_r;
    pc_next_s       = pc_r;
    redirect_next_s = redirect_r;
    load_ifid       = 1'b0;
    ifid_rst        = flush_s;
    idex_rst        = flush_s | (advance_s & ~ifid_valid_r);

    case (state_r)
      FR_BOOT: begin
        ifid_rst     = 1'b1;
        idex_rst     = 1'b1;
        state_next_s = FR_FETCH;
      end
      FR_FETCH: begin
        if (flush_s) begin
          if (imem_resp) begin
            // Response in hand: drop it and go straight to the new target.
            pc_next_s = recv_addr;
          end else begin
            // Miss outstanding: remember the target, wait out the response.
            redirect_next_s = recv_addr;
            state_next_s    = FR_DRAIN;
          end
        end else if (accept_s) begin
          load_ifid = 1'b1;
          pc_next_s = pred_addr;
        end else begin
          pc_next_s = pc_r;
        end
      end
      FR_DRAIN: begin
        // The newest redirect always wins, including one arriving now.
        if (flush_s) begin
          redirect_next_s = recv_addr;
        end else begin
          redirect_next_s = redirect_r;
        end
        if (imem_resp) begin
          pc_next_s    = flush_s ? recv_addr : redirect_r;
          state_next_s = FR_FETCH;
        end else begin
          pc_next_s = pc_r;
        end
      end
      default: begin
        state_next_s = FR_BOOT;
      end
    endcase

    if (flush_s) begin
      ifid_valid_next_s = 1'b0;
    end else if (load_ifid) begin
      ifid_valid_next_s = 1'b1;
    end else if (advance_s) begin
      ifid_valid_next_s = 1'b0;
    end else begin
      ifid_valid_next_s = ifid_valid_r;
    end
  end

  // State, PC, pending redirect and IF/ID occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= FR_BOOT;
      pc_r         <= RESET_PC;
      redirect_r   <= 32'h0000_0000;
      ifid_valid_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      pc_r         <= pc_next_s;
      redirect_r   <= redirect_next_s;
      ifid_valid_r <= ifid_valid_next_s;
    end
  end

  // Saturating count of acted-on mispredictions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= 32'h0000_0000;
    end else if (flush_s) begin
      count_r <= sat_inc(count_r);
    end else begin
      count_r <= count_r;
    end
  end

endmodule
